// File: rtl/memory_access.sv
// memory_access: pipeline memory stage. Non-memory ops pass alu_result straight
//   to writeback. Loads and stores issue one word-aligned request and wait for
//   dmem_ready. An access that never completes is aborted with bus_err.
// Latency: 1 cycle for pass-through ops; at least 2 cycles for memory ops,
//   and TIMEOUT_CYCLES+1 cycles when the access is aborted.
// Backpressure: stall is high while an access is outstanding. Upstream holds
//   its inputs, and mem_pipeline_ctl_in is ignored during that time.
// Ports:
//   clk, rst (async active-low)
//   alucode, alu_result, rs2, mem_pipeline_ctl_in : inputs from the execute stage
//   dmem_addr, dmem_wdata, dmem_we, dmem_re       : memory request outputs
//   dmem_rdata, dmem_ready                        : memory response inputs
//   wb_data, mem_pipeline_ctl_out, stall, bus_err : outputs to writeback and upstream
//   misalign                                      : present only when the
//                                                   MISALIGN_TRAP_EN macro is defined
module memory_access #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  alucode,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2,
  input  logic        mem_pipeline_ctl_in,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_we,
  output logic        dmem_re,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] wb_data,
  output logic        mem_pipeline_ctl_out,
  output logic        stall,
  output logic        bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  // Op codes matching the ALU_* values in define.vh.
  localparam logic [5:0] ALU_LB  = 6'd19;
  localparam logic [5:0] ALU_LH  = 6'd20;
  localparam logic [5:0] ALU_LW  = 6'd21;
  localparam logic [5:0] ALU_LBU = 6'd22;
  localparam logic [5:0] ALU_LHU = 6'd23;
  localparam logic [5:0] ALU_SB  = 6'd24;
  localparam logic [5:0] ALU_SH  = 6'd25;
  localparam logic [5:0] ALU_SW  = 6'd26;

  localparam logic IDLE   = 1'b0;
  localparam logic ACCESS = 1'b1;

  localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic        state;
  logic [31:0] addr_q;     // full effective address; also the store writeback value
  logic [5:0]  op_q;
  logic [31:0] wait_cnt;

  logic        is_load;
  logic        is_store;
  logic [31:0] st_wdata;
  logic [3:0]  st_we;
  logic        bad_align;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode the incoming op.
  always_comb begin
    is_load  = (alucode == ALU_LB) || (alucode == ALU_LH) || (alucode == ALU_LW) ||
               (alucode == ALU_LBU) || (alucode == ALU_LHU);
    is_store = (alucode == ALU_SB) || (alucode == ALU_SH) || (alucode == ALU_SW);
    st_wdata = 32'h0;
    st_we    = 4'b0000;
    case (alucode)
      ALU_SB: begin
        st_wdata = {4{rs2[7:0]}};
        st_we    = 4'b0001 << alu_result[1:0];
      end
      ALU_SH: begin
        st_wdata = {2{rs2[15:0]}};
        st_we    = alu_result[1] ? 4'b1100 : 4'b0011;
      end
      ALU_SW: begin
        st_wdata = rs2;
        st_we    = 4'b1111;
      end
      default: ;
    endcase
`ifdef MISALIGN_TRAP_EN
    bad_align = (((alucode == ALU_LH) || (alucode == ALU_LHU) || (alucode == ALU_SH)) &&
                 alu_result[0]) ||
                (((alucode == ALU_LW) || (alucode == ALU_SW)) && (alu_result[1:0] != 2'b00));
`else
    // Low address bits only steer lanes; every memory op is issued.
    bad_align = 1'b0;
`endif
  end

  // Lane selection and extension of the returned read word. The lanes are
  // picked from the latched address, not the live input.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q)
      ALU_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      ALU_LBU: ld_data = {24'h0, ld_byte};
      ALU_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      ALU_LHU: ld_data = {16'h0, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      addr_q               <= 32'h0;
      op_q                 <= 6'h0;
      wait_cnt             <= 32'h0;
      dmem_wdata           <= 32'h0;
      dmem_we              <= 4'b0000;
      dmem_re              <= 1'b0;
      wb_data              <= 32'h0;
      mem_pipeline_ctl_out <= 1'b0;
      bus_err              <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign             <= 1'b0;
`endif
    end else begin
      // These outputs are single-cycle pulses.
      mem_pipeline_ctl_out <= 1'b0;
      bus_err              <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign             <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_pipeline_ctl_in) begin
            if ((is_load || is_store) && !bad_align) begin
              addr_q     <= alu_result;
              op_q       <= alucode;
              dmem_wdata <= st_wdata;
              dmem_we    <= st_we;
              dmem_re    <= is_load;
              wait_cnt   <= 32'h0;
              state      <= ACCESS;
            end else if (bad_align) begin
              wb_data              <= 32'h0;
              mem_pipeline_ctl_out <= 1'b1;
`ifdef MISALIGN_TRAP_EN
              misalign             <= 1'b1;
`endif
            end else begin
              wb_data              <= alu_result;
              mem_pipeline_ctl_out <= 1'b1;
            end
          end
        end
        default: begin
          // ACCESS. If ready and the timeout land on the same cycle, ready wins.
          if (dmem_ready) begin
            wb_data              <= dmem_re ? ld_data : addr_q;
            mem_pipeline_ctl_out <= 1'b1;
            dmem_we              <= 4'b0000;
            dmem_re              <= 1'b0;
            state                <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            wb_data              <= 32'h0;
            mem_pipeline_ctl_out <= 1'b1;
            bus_err              <= 1'b1;
            dmem_we              <= 4'b0000;
            dmem_re              <= 1'b0;
            state                <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign dmem_addr = {addr_q[31:2], 2'b00};
  assign stall     = (state == ACCESS);

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd19;
  localparam logic [5:0] ALU_LH  = 6'd20;
  localparam logic [5:0] ALU_LW  = 6'd21;
  localparam logic [5:0] ALU_LBU = 6'd22;
  localparam logic [5:0] ALU_LHU = 6'd23;
  localparam logic [5:0] ALU_SB  = 6'd24;
  localparam logic [5:0] ALU_SH  = 6'd25;
  localparam logic [5:0] ALU_SW  = 6'd26;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  alucode;
  logic [31:0] alu_result;
  logic [31:0] rs2;
  logic        ctl_in;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [31:0] wb_data;
  logic        ctl_out;
  logic        stall;
  logic        bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .alucode(alucode),
    .alu_result(alu_result),
    .rs2(rs2),
    .mem_pipeline_ctl_in(ctl_in),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we),
    .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .wb_data(wb_data),
    .mem_pipeline_ctl_out(ctl_out),
    .stall(stall),
    .bus_err(bus_err)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign(misalign)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string nm);
    chk({nm, ".ctl_out"}, 32'(ctl_out), 32'd0);
    chk({nm, ".stall"}, 32'(stall), 32'd0);
    chk({nm, ".bus_err"}, 32'(bus_err), 32'd0);
    chk({nm, ".re"}, 32'(dmem_re), 32'd0);
    chk({nm, ".we"}, 32'(dmem_we), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk_idle_zero(nm);
    chk({nm, ".wb"}, wb_data, 32'd0);
    chk({nm, ".addr"}, dmem_addr, 32'd0);
    chk({nm, ".wdata"}, dmem_wdata, 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        mem;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_we;
    logic        e_re;
    logic [31:0] e_wb;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  // Hard stop if something wedges the bench.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{ALU_ADD, 32'h00001234, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h00001234};
    vt[1]  = '{ALU_ADD, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'hFFFFFFFF};
    vt[2]  = '{ALU_LB,  32'h00000103, 32'h0, 32'h80AABBCC, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'hFFFFFF80};
    vt[3]  = '{ALU_LBU, 32'h00000103, 32'h0, 32'h80AABBCC, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h00000080};
    vt[4]  = '{ALU_LB,  32'h00000101, 32'h0, 32'h80AABBCC, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'hFFFFFFBB};
    vt[5]  = '{ALU_LBU, 32'h00000100, 32'h0, 32'h80AABBCC, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h000000CC};
    vt[6]  = '{ALU_LH,  32'h00000102, 32'h0, 32'h80AABBCC, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'hFFFF80AA};
    vt[7]  = '{ALU_LHU, 32'h00000100, 32'h0, 32'h80AABBCC, 1'b1, 32'h100, 32'h0, 4'h0, 1'b1, 32'h0000BBCC};
    vt[8]  = '{ALU_LH,  32'h00000200, 32'h0, 32'h00007FFF, 1'b1, 32'h200, 32'h0, 4'h0, 1'b1, 32'h00007FFF};
    vt[9]  = '{ALU_LW,  32'h00000400, 32'h0, 32'h12345678, 1'b1, 32'h400, 32'h0, 4'h0, 1'b1, 32'h12345678};
    vt[10] = '{ALU_SB,  32'h00000501, 32'hDEADBEEF, 32'h0, 1'b1, 32'h500, 32'hEFEFEFEF, 4'b0010, 1'b0, 32'h00000501};
    vt[11] = '{ALU_SH,  32'h00000202, 32'hDEADBEEF, 32'h0, 1'b1, 32'h200, 32'hBEEFBEEF, 4'b1100, 1'b0, 32'h00000202};
    vt[12] = '{ALU_SH,  32'h00000200, 32'hDEADBEEF, 32'h0, 1'b1, 32'h200, 32'hBEEFBEEF, 4'b0011, 1'b0, 32'h00000200};
    vt[13] = '{ALU_SW,  32'h00000604, 32'hCAFEF00D, 32'h0, 1'b1, 32'h604, 32'hCAFEF00D, 4'b1111, 1'b0, 32'h00000604};
    vt[14] = '{ALU_SB,  32'h00000503, 32'hDEADBEEF, 32'h0, 1'b1, 32'h500, 32'hEFEFEFEF, 4'b1000, 1'b0, 32'h00000503};

    rst = 1'b0; alucode = ALU_ADD; alu_result = 32'h0; rs2 = 32'h0;
    ctl_in = 1'b0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Ready in IDLE must do nothing.
    dmem_ready = 1'b1;
    @(negedge clk);
    chk_idle_zero("idle_ready");
    dmem_ready = 1'b0;

    // Table-driven vectors; memory ops complete on their first ACCESS cycle.
    for (int i = 0; i < NV; i++) begin
      alucode = vt[i].op; alu_result = vt[i].a; rs2 = vt[i].d; ctl_in = 1'b1;
      @(negedge clk);
      ctl_in = 1'b0;
      // Scramble live inputs: the outstanding request must use latched values.
      alu_result = ~vt[i].a; rs2 = ~vt[i].d;
      if (vt[i].mem) begin
        chk($sformatf("v%0d.stall", i), 32'(stall), 32'd1);
        chk($sformatf("v%0d.ctl_early", i), 32'(ctl_out), 32'd0);
        chk($sformatf("v%0d.addr", i), dmem_addr, vt[i].e_addr);
        chk($sformatf("v%0d.re", i), 32'(dmem_re), 32'(vt[i].e_re));
        chk($sformatf("v%0d.we", i), 32'(dmem_we), 32'(vt[i].e_we));
        if (vt[i].e_we != 4'h0) chk($sformatf("v%0d.wdata", i), dmem_wdata, vt[i].e_wdata);
        dmem_rdata = vt[i].rd; dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
        chk($sformatf("v%0d.re_done", i), 32'(dmem_re), 32'd0);
        chk($sformatf("v%0d.we_done", i), 32'(dmem_we), 32'd0);
      end
      chk($sformatf("v%0d.ctl_out", i), 32'(ctl_out), 32'd1);
      chk($sformatf("v%0d.wb", i), wb_data, vt[i].e_wb);
      chk($sformatf("v%0d.stall_done", i), 32'(stall), 32'd0);
      chk($sformatf("v%0d.bus_err", i), 32'(bus_err), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d.ctl_pulse", i), 32'(ctl_out), 32'd0);
    end

    // LB with ready after 3 ACCESS cycles; ctl_in pulses during ACCESS are ignored.
    alucode = ALU_LB; alu_result = 32'h103; ctl_in = 1'b1;
    @(negedge clk);
    alucode = ALU_ADD; alu_result = 32'h9999;
    for (int c = 0; c < 2; c++) begin
      chk("lb3.stall", 32'(stall), 32'd1);
      chk("lb3.re", 32'(dmem_re), 32'd1);
      chk("lb3.addr", dmem_addr, 32'h100);
      chk("lb3.ctl_out", 32'(ctl_out), 32'd0);
      @(negedge clk);
    end
    ctl_in = 1'b0; dmem_rdata = 32'h80AABBCC; dmem_ready = 1'b1;
    chk("lb3.re3", 32'(dmem_re), 32'd1);
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("lb3.ctl_done", 32'(ctl_out), 32'd1);
    chk("lb3.wb", wb_data, 32'hFFFFFF80);
    chk("lb3.stall_done", 32'(stall), 32'd0);
    @(negedge clk);
    chk("lb3.ignored_in", 32'(ctl_out), 32'd0);

    // Timeout: LW never gets ready, aborts after 4 ACCESS cycles.
    alucode = ALU_LW; alu_result = 32'h700; ctl_in = 1'b1;
    @(negedge clk);
    ctl_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("to.stall", 32'(stall), 32'd1);
      chk("to.bus_err_early", 32'(bus_err), 32'd0);
      chk("to.ctl_early", 32'(ctl_out), 32'd0);
      @(negedge clk);
    end
    chk("to.bus_err", 32'(bus_err), 32'd1);
    chk("to.ctl_out", 32'(ctl_out), 32'd1);
    chk("to.wb", wb_data, 32'h0);
    chk("to.stall_done", 32'(stall), 32'd0);
    chk("to.re_done", 32'(dmem_re), 32'd0);
    @(negedge clk);
    chk("to.bus_err_pulse", 32'(bus_err), 32'd0);

    // Ready on the 4th ACCESS cycle wins over the timeout.
    alucode = ALU_LW; alu_result = 32'h704; ctl_in = 1'b1;
    @(negedge clk);
    ctl_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("race.stall", 32'(stall), 32'd1);
    dmem_rdata = 32'h55AA55AA; dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("race.ctl_out", 32'(ctl_out), 32'd1);
    chk("race.bus_err", 32'(bus_err), 32'd0);
    chk("race.wb", wb_data, 32'h55AA55AA);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    alucode = ALU_LW; alu_result = 32'h800; ctl_in = 1'b1;
    @(negedge clk);
    ctl_in = 1'b0;
    chk("rstmid.re_before", 32'(dmem_re), 32'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rstmid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_zero("post_rst");
    alucode = ALU_SW; alu_result = 32'h904; rs2 = 32'h11223344; ctl_in = 1'b1;
    @(negedge clk);
    ctl_in = 1'b0;
    chk("sw.we", 32'(dmem_we), 32'hF);
    chk("sw.wdata", dmem_wdata, 32'h11223344);
    chk("sw.addr", dmem_addr, 32'h904);
    dmem_ready = 1'b1;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("sw.ctl_out", 32'(ctl_out), 32'd1);
    chk("sw.wb", wb_data, 32'h904);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    alucode = ALU_LW; alu_result = 32'h301; ctl_in = 1'b1;
    @(negedge clk);
    ctl_in = 1'b0;
    chk("mis.flag", 32'(misalign), 32'd1);
    chk("mis.ctl_out", 32'(ctl_out), 32'd1);
    chk("mis.wb", wb_data, 32'h0);
    chk("mis.re", 32'(dmem_re), 32'd0);
    chk("mis.stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("mis.pulse", 32'(misalign), 32'd0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
